// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: arbitrates two fetch-lane misses, issues one
// line request per distinct miss and streams the returned beats into the cache fill port.
module icache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned BEAT_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss0,
    input  logic                  miss1,
    input  logic [ADDR_WIDTH-1:0] miss_addr0,
    input  logic [ADDR_WIDTH-1:0] miss_addr1,
    input  logic                  ext_flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [63:0]           mem_resp_data,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_addr_valid,
    output logic [63:0]           fetched_data,
    output logic                  busy
);

    localparam int unsigned BEATS   = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned OFF_W   = $clog2(LINE_BYTES);
    localparam int unsigned BEAT_SH = $clog2(BEAT_BYTES);
    localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StReq, StResp, StDrain, StDone} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_line_q, cur_line_d;
    logic [ADDR_WIDTH-1:0] pend_line_q, pend_line_d;
    logic                  pending_q, pending_d;
    logic                  flushed_q, flushed_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  fill_valid_q, fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [63:0]           fill_data_q, fill_data_d;

    logic [ADDR_WIDTH-1:0] base0, base1, beat_addr;
    logic                  last_beat;

    assign base0     = miss_addr0 & ~OFF_MASK;
    assign base1     = miss_addr1 & ~OFF_MASK;
    assign beat_addr = cur_line_q + (ADDR_WIDTH'(beat_cnt_q) << BEAT_SH);
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        cur_line_d   = cur_line_q;
        pend_line_d  = pend_line_q;
        pending_d    = pending_q;
        flushed_d    = flushed_q;
        beat_cnt_d   = beat_cnt_q;
        fill_valid_d = 1'b0;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;

        // A flush in any state abandons the queued second-lane refill.
        if (ext_flush) pending_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if ((miss0 || miss1) && !ext_flush) begin
                    cur_line_d = miss0 ? base0 : base1;
                    if (miss0 && miss1 && (base0 != base1)) begin
                        pend_line_d = base1;
                        pending_d   = 1'b1;
                    end
                    state_d = StReq;
                end
            end
            StReq: begin
                // The request cannot be withdrawn; remember the flush and drain later.
                if (ext_flush) flushed_d = 1'b1;
                if (mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = (flushed_q || ext_flush) ? StDrain : StResp;
                end
            end
            StResp: begin
                if (mem_resp_valid) begin
                    fill_valid_d = 1'b1;
                    fill_addr_d  = beat_addr;
                    fill_data_d  = mem_resp_data;
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                end
                if (mem_resp_valid && last_beat) begin
                    if (pending_q && !ext_flush) begin
                        cur_line_d = pend_line_q;
                        pending_d  = 1'b0;
                        state_d    = StReq;
                    end else begin
                        state_d = StDone;
                    end
                end else if (ext_flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        flushed_d = 1'b0;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_line_q   <= '0;
            pend_line_q  <= '0;
            pending_q    <= 1'b0;
            flushed_q    <= 1'b0;
            beat_cnt_q   <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_line_q   <= cur_line_d;
            pend_line_q  <= pend_line_d;
            pending_q    <= pending_d;
            flushed_q    <= flushed_d;
            beat_cnt_q   <= beat_cnt_d;
            fill_valid_q <= fill_valid_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign mem_req_valid    = (state_q == StReq);
    assign mem_req_addr     = mem_req_valid ? cur_line_q : '0;
    assign busy             = (state_q != StIdle);
    assign fetch_addr_valid = fill_valid_q;
    assign fetch_addr       = fill_addr_q;
    assign fetched_data     = fill_data_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequences line refills for the instruction cache after a fetch-lane miss. Arbitrates the two fetch-lane miss requests and issues one line request per miss to the memory side.
- Streams returned beats into the cache fill port (fetch_addr / fetch_addr_valid / fetched_data). Sits between the fetch stage and the memory interface.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH: address width.
- LINE_BYTES, 32: cache line size in bytes; power of two, at least 8.
- BEAT_BYTES, 8: bytes per fill beat (two 32-bit instructions); fixed by the 64-bit fill port.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- miss0  in  1  lane 0 cache miss
- miss1  in  1  lane 1 cache miss
- miss_addr0  in  ADDR_WIDTH  lane 0 miss address; valid while miss0=1
- miss_addr1  in  ADDR_WIDTH  lane 1 miss address; valid while miss1=1
- ext_flush  in  1  pipeline flush
- mem_req_valid  out  1  line request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  line-aligned request address
- mem_resp_valid  in  1  response beat valid; no backpressure
- mem_resp_data  in  64  response beat data
- fetch_addr  out  ADDR_WIDTH  fill beat address
- fetch_addr_valid  out  1  fill beat strobe
- fetched_data  out  64  fill beat data
- busy  out  1  refill in progress (state != IDLE)

Behaviour:
- Reset value of every output is 0. State = IDLE; pending, flushed and beat counter cleared. Reset mid-operation aborts immediately; the memory side is reset in the same cycle.
- BEATS = LINE_BYTES/BEAT_BYTES. Line base = addr with the low log2(LINE_BYTES) bits cleared.
- States: IDLE, REQ, RESP, DRAIN, DONE.
- IDLE: if miss0 or miss1 (and not ext_flush), capture the line base into cur_line and enter REQ.
  - Lane 0 has priority.
  - If both lanes miss and their line bases differ, the lane 1 base is stored in pend_line with pending=1.
  - If both lanes miss on the same line, a single refill is issued.
- REQ: mem_req_valid=1, mem_req_addr=cur_line, held stable until mem_req_ready. On handshake, clear beat_cnt; go to RESP, or to DRAIN if flushed=1.
- RESP: each mem_resp_valid beat is registered and presented the next cycle:
  - fetch_addr_valid=1 for one cycle, fetch_addr = cur_line + beat_cnt*BEAT_BYTES, fetched_data = that beat's data.
  - Beats fill in order; no critical-word-first. Gaps between beats are allowed.
  - Last beat (beat_cnt=BEATS-1): go to REQ with cur_line=pend_line and pending cleared if pending=1; otherwise go to DONE.
- DONE: one cycle; miss inputs ignored so a stale miss cannot re-request. Then IDLE.
- ext_flush:
  - In IDLE: no capture.
  - In REQ before handshake: set flushed=1 and keep the request up. Dropping it is illegal; enter DRAIN on handshake.
  - In RESP: enter DRAIN.
  - Any flush clears pending.
- DRAIN: count the remaining beats with fetch_addr_valid held at 0, then go to DONE and clear flushed.
  - A beat arriving in the same cycle as a flush in RESP is still written to the cache.
- Miss inputs are ignored outside IDLE.
- fetch_addr wraps within cur_line only; the line base never increments.
- Only one memory request is outstanding at a time.

Test Plan:
- LINE_BYTES=32. miss0=1, miss_addr0=0x1234; mem_req_ready=1 the next cycle; 4 consecutive beats D0..D3 → mem_req_addr=0x1220; fetch_addr_valid pulses with fetch_addr 0x1220, 0x1228, 0x1230, 0x1238 and D0..D3, each one cycle after its beat; busy=0 two cycles after the last fill.
- miss0 and miss1 together with addrs 0x100 and 0x104 → exactly one request, to 0x100.
- miss0=0x100, miss1=0x200 together → request 0x100, 4 fills, then request 0x200, 4 fills, with no IDLE between.
- mem_req_ready low for 5 cycles, with gaps of 3 cycles between beats → mem_req_valid and mem_req_addr stable throughout; fill order and addresses unchanged.
- ext_flush after beat 1 of a 0x100 refill that has 0x200 pending → fills 0x100 and 0x108 only; remaining beats drained with no fetch_addr_valid; no 0x200 request; busy returns to 0.
- reset asserted in RESP → all outputs 0 the next cycle; a new miss0 afterwards starts a clean refill.
